// File: rtl/psg_wave_bus_master.sv
// psg_wave_bus_master: runs one system-bus read for the channel granted by the
// PSG 8-channel arbiter and returns the data tagged with the channel number.
// Latency: 4 clks minimum per transaction (IDLE, GRANT, BUS, DONE); BUS lasts until ack_i or TMO clks.
// Backpressure: arb_ack is high only in IDLE, so the arbiter re-arbitrates only when the bus is free.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   ce              clock enable shared with the arbiter (gates IDLE->GRANT only)
//   req, sel, seln  channel requests, arbiter one-hot grant and encoded owner
//   ch_adr          per-channel addresses, channel n at [n*AW +: AW]
//   arb_ack         to arbiter: high = idle, may re-arbitrate
//   cyc_o, stb_o, adr_o, dat_i, ack_i   system-bus read master
//   rd_vld, rd_ch, rd_dat, rd_err       read result; rd_err marks a timed-out read
module psg_wave_bus_master #(
    parameter int AW  = 24,
    parameter int DW  = 16,
    parameter int TMO = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ce,
    input  logic [7:0]      req,
    input  logic [7:0]      sel,
    input  logic [2:0]      seln,
    input  logic [8*AW-1:0] ch_adr,
    output logic            arb_ack,
    output logic            cyc_o,
    output logic            stb_o,
    output logic [AW-1:0]   adr_o,
    input  logic [DW-1:0]   dat_i,
    input  logic            ack_i,
    output logic            rd_vld,
    output logic [2:0]      rd_ch,
    output logic [DW-1:0]   rd_dat,
    output logic            rd_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        BUS   = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Counter value on the last BUS cycle before giving up.
    localparam logic [15:0] TMO_LAST = 16'(TMO - 1);

    state_t          state_q, state_d;
    logic            cyc_q, cyc_d;
    logic [AW-1:0]   adr_q, adr_d;
    logic            rd_vld_q, rd_vld_d;
    logic [2:0]      rd_ch_q, rd_ch_d;
    logic [DW-1:0]   rd_dat_q, rd_dat_d;
    logic            rd_err_q, rd_err_d;
    logic [15:0]     cnt_q, cnt_d;

    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        adr_d    = adr_q;
        rd_vld_d = 1'b0;
        rd_ch_d  = rd_ch_q;
        rd_dat_d = rd_dat_q;
        rd_err_d = rd_err_q;
        cnt_d    = cnt_q;

        case (state_q)
            IDLE: begin
                // The arbiter samples requests on this same edge.
                if (ce) begin
                    state_d = GRANT;
                end
            end
            GRANT: begin
                // Skip the bus cycle if there is no owner, or the arbiter is
                // holding a stale owner whose request has already dropped.
                if ((|sel) && req[seln]) begin
                    state_d = BUS;
                    cyc_d   = 1'b1;
                    adr_d   = ch_adr[int'(seln)*AW +: AW];
                    rd_ch_d = seln;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            BUS: begin
                // Counts every clk regardless of ce so a stalled bus still times out.
                cnt_d = cnt_q + 16'd1;
                if (ack_i) begin
                    state_d  = DONE;
                    cyc_d    = 1'b0;
                    rd_dat_d = dat_i;
                    rd_err_d = 1'b0;
                    rd_vld_d = 1'b1;
                end else if (cnt_q == TMO_LAST) begin
                    state_d  = DONE;
                    cyc_d    = 1'b0;
                    rd_dat_d = '0;
                    rd_err_d = 1'b1;
                    rd_vld_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cyc_q    <= 1'b0;
            adr_q    <= '0;
            rd_vld_q <= 1'b0;
            rd_ch_q  <= '0;
            rd_dat_q <= '0;
            rd_err_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            adr_q    <= adr_d;
            rd_vld_q <= rd_vld_d;
            rd_ch_q  <= rd_ch_d;
            rd_dat_q <= rd_dat_d;
            rd_err_q <= rd_err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign arb_ack = (state_q == IDLE);
    assign cyc_o   = cyc_q;
    assign stb_o   = cyc_q;
    assign adr_o   = adr_q;
    assign rd_vld  = rd_vld_q;
    assign rd_ch   = rd_ch_q;
    assign rd_dat  = rd_dat_q;
    assign rd_err  = rd_err_q;

endmodule

// File: tb/tb_psg_wave_bus_master.sv
// tb_psg_wave_bus_master: directed bench for psg_wave_bus_master with a small
// fixed-priority arbiter model (lowest channel wins, holds owner when no request).
// Inputs change 1 time unit after each rising edge; outputs are observed there too.
module tb_psg_wave_bus_master;

    localparam int AW  = 24;
    localparam int DW  = 16;
    localparam int TMO = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            ce;
    logic [7:0]      req;
    logic [7:0]      sel;
    logic [2:0]      seln;
    logic [8*AW-1:0] ch_adr;
    logic            arb_ack;
    logic            cyc_o;
    logic            stb_o;
    logic [AW-1:0]   adr_o;
    logic [DW-1:0]   dat_i;
    logic            ack_i;
    logic            rd_vld;
    logic [2:0]      rd_ch;
    logic [DW-1:0]   rd_dat;
    logic            rd_err;

    int checks = 0;
    int errors = 0;

    psg_wave_bus_master #(.AW(AW), .DW(DW), .TMO(TMO)) dut (
        .clk     (clk),
        .rst     (rst),
        .ce      (ce),
        .req     (req),
        .sel     (sel),
        .seln    (seln),
        .ch_adr  (ch_adr),
        .arb_ack (arb_ack),
        .cyc_o   (cyc_o),
        .stb_o   (stb_o),
        .adr_o   (adr_o),
        .dat_i   (dat_i),
        .ack_i   (ack_i),
        .rd_vld  (rd_vld),
        .rd_ch   (rd_ch),
        .rd_dat  (rd_dat),
        .rd_err  (rd_err)
    );

    always #5 clk = ~clk;

    // Arbiter model: updates the grant at an edge where ce & arb_ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel  <= 8'h00;
            seln <= 3'd0;
        end else if (ce && arb_ack && (|req)) begin
            for (int i = 7; i >= 0; i--) begin
                if (req[i]) begin
                    sel  <= 8'(1 << i);
                    seln <= 3'(i);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Ticks until rd_vld is seen; n = ticks taken, or -1 if the budget expires.
    task automatic wait_vld(input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            tick();
            if (rd_vld) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic settle();
        ce  = 1'b0;
        req = 8'h00;
        repeat (3) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int cyc_cnt;
        int vld_cnt;
        int bad;
        int vld_err;
        logic prev_ack;

        rst    = 1'b1;
        ce     = 1'b0;
        req    = 8'h00;
        ack_i  = 1'b0;
        dat_i  = 16'h0000;
        for (int c = 0; c < 8; c++) ch_adr[c*AW +: AW] = 24'hA00000 + 24'(c);
        ch_adr[2*AW +: AW] = 24'h001234;
        tick();
        tick();

        // Reset state
        chk("rst_cyc",    32'(cyc_o),   32'd0);
        chk("rst_stb",    32'(stb_o),   32'd0);
        chk("rst_adr",    32'(adr_o),   32'd0);
        chk("rst_vld",    32'(rd_vld),  32'd0);
        chk("rst_ch",     32'(rd_ch),   32'd0);
        chk("rst_dat",    32'(rd_dat),  32'd0);
        chk("rst_err",    32'(rd_err),  32'd0);
        chk("rst_arbak",  32'(arb_ack), 32'd1);
        rst = 1'b0;

        // Single read on ch2, ack 2 clks after stb
        ce  = 1'b1;
        req = 8'h04;
        tick();                                  // GRANT
        chk("sr_grant_arbak", 32'(arb_ack), 32'd0);
        chk("sr_grant_cyc",   32'(cyc_o),   32'd0);
        tick();                                  // BUS
        chk("sr_bus_cyc",   32'(cyc_o),   32'd1);
        chk("sr_bus_stb",   32'(stb_o),   32'd1);
        chk("sr_bus_adr",   32'(adr_o),   32'h001234);
        chk("sr_bus_arbak", 32'(arb_ack), 32'd0);
        tick();                                  // BUS, second clk
        chk("sr_bus2_cyc", 32'(cyc_o), 32'd1);
        chk("sr_bus2_adr", 32'(adr_o), 32'h001234);
        chk("sr_bus2_vld", 32'(rd_vld), 32'd0);
        ack_i = 1'b1;
        dat_i = 16'hBEEF;
        tick();                                  // DONE
        ack_i = 1'b0;
        dat_i = 16'h0000;
        req   = 8'h00;
        chk("sr_done_vld",   32'(rd_vld),  32'd1);
        chk("sr_done_ch",    32'(rd_ch),   32'd2);
        chk("sr_done_dat",   32'(rd_dat),  32'hBEEF);
        chk("sr_done_err",   32'(rd_err),  32'd0);
        chk("sr_done_cyc",   32'(cyc_o),   32'd0);
        chk("sr_done_arbak", 32'(arb_ack), 32'd0);
        tick();                                  // IDLE
        chk("sr_idle_vld",   32'(rd_vld),  32'd0);
        chk("sr_idle_arbak", 32'(arb_ack), 32'd1);
        chk("sr_hold_dat",   32'(rd_dat),  32'hBEEF);
        settle();

        // Priority and back-to-back: ch0 before ch7, 4 clks apart
        ce    = 1'b1;
        req   = 8'h81;
        ack_i = 1'b1;
        dat_i = 16'hA5A5;
        wait_vld(10, n);
        chk("pri_first_lat", 32'(n),      32'd3);
        chk("pri_first_ch",  32'(rd_ch),  32'd0);
        chk("pri_first_dat", 32'(rd_dat), 32'hA5A5);
        req = 8'h80;
        wait_vld(10, n);
        chk("pri_spacing",   32'(n),      32'd4);
        chk("pri_second_ch", 32'(rd_ch),  32'd7);
        chk("pri_second_adr", 32'(adr_o), 32'hA00007);
        ack_i = 1'b0;
        settle();

        // Timeout on ch3: cyc_o high exactly TMO clks
        ce  = 1'b1;
        req = 8'h08;
        for (int i = 0; i < 5 && !cyc_o; i++) tick();
        cyc_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            if (!cyc_o) break;
            cyc_cnt++;
            tick();
        end
        chk("tmo_cyc_len", 32'(cyc_cnt), 32'(TMO));
        chk("tmo_vld",     32'(rd_vld),  32'd1);
        chk("tmo_err",     32'(rd_err),  32'd1);
        chk("tmo_dat",     32'(rd_dat),  32'd0);
        chk("tmo_ch",      32'(rd_ch),   32'd3);
        req = 8'h00;
        tick();
        chk("tmo_arbak",   32'(arb_ack), 32'd1);
        chk("tmo_vld_end", 32'(rd_vld),  32'd0);
        settle();

        // Reset in the middle of a bus cycle on ch3
        ce  = 1'b1;
        req = 8'h08;
        tick();
        tick();
        chk("rmb_cyc_before", 32'(cyc_o), 32'd1);
        rst = 1'b1;
        ce  = 1'b0;
        req = 8'h00;
        tick();
        rst = 1'b0;
        chk("rmb_cyc",   32'(cyc_o),   32'd0);
        chk("rmb_stb",   32'(stb_o),   32'd0);
        chk("rmb_arbak", 32'(arb_ack), 32'd1);
        chk("rmb_err",   32'(rd_err),  32'd0);
        chk("rmb_ch",    32'(rd_ch),   32'd0);
        vld_cnt = (rd_vld) ? 1 : 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rd_vld) vld_cnt++;
        end
        chk("rmb_no_vld", 32'(vld_cnt), 32'd0);

        // Stale owner: ch5 completes, drops req, next GRANT runs no bus cycle
        ce    = 1'b1;
        req   = 8'h20;
        ack_i = 1'b1;
        dat_i = 16'h5A5A;
        wait_vld(10, n);
        chk("st_lat", 32'(n),     32'd3);
        chk("st_ch",  32'(rd_ch), 32'd5);
        req   = 8'h00;
        ack_i = 1'b0;
        cyc_cnt = 0;
        vld_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (cyc_o) cyc_cnt++;
            if (rd_vld) vld_cnt++;
        end
        chk("st_no_cyc",  32'(cyc_cnt), 32'd0);
        chk("st_no_vld",  32'(vld_cnt), 32'd0);
        chk("st_hold_ch", 32'(rd_ch),   32'd5);
        settle();

        // ce gating: ce high 1 clk in 4, ch1 requesting, bus never acks
        req      = 8'h02;
        ack_i    = 1'b0;
        cyc_cnt  = 0;
        vld_cnt  = 0;
        bad      = 0;
        vld_err  = 0;
        prev_ack = arb_ack;
        for (int k = 0; k < 24; k++) begin
            ce = (k % 4 == 0);
            tick();
            if (prev_ack && !arb_ack && !ce) bad++;
            if (cyc_o) cyc_cnt++;
            if (rd_vld) begin
                vld_cnt++;
                if (rd_err) vld_err++;
                req = 8'h00;
            end
            prev_ack = arb_ack;
        end
        chk("ce_grant_gated", 32'(bad),     32'd0);
        chk("ce_cyc_len",     32'(cyc_cnt), 32'(TMO));
        chk("ce_vld_cnt",     32'(vld_cnt), 32'd1);
        chk("ce_vld_err",     32'(vld_err), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/psg_wave_bus_master.md
Name: psg_wave_bus_master

Overview:
- Downstream of the PSG 8-channel bus arbiter. Consumes the arbiter's one-hot grant (sel[7:0]) and encoded owner (seln).
- Runs one system-bus read cycle for the granted wave-table channel. Returns the read data tagged with the channel number.
- Generates the arbiter's "transfer completed" (ack) input, so the arbiter re-arbitrates only when the bus is idle.
- A timeout counter guarantees forward progress if the system bus never acknowledges.

Parameters:
AW, 24, system-bus address width
DW, 16, system-bus data width
TMO, 255, bus-cycle timeout in clk cycles (1..2^16-1)

Ports:
clk      in   1      clock
rst      in   1      synchronous active-high reset
ce       in   1      clock enable, shared with arbiter
req      in   8      channel request lines (same wires feeding arbiter)
sel      in   8      arbiter one-hot grant
seln     in   3      arbiter encoded owner
ch_adr   in   8*AW   channel addresses; channel n at bits [n*AW +: AW]
arb_ack  out  1      to arbiter ack input; high = idle, may re-arbitrate
cyc_o    out  1      system-bus cycle
stb_o    out  1      system-bus strobe
adr_o    out  AW     system-bus address
dat_i    in   DW     system-bus read data
ack_i    in   1      system-bus acknowledge
rd_vld   out  1      one-clk pulse: read result valid
rd_ch    out  3      channel the result belongs to
rd_dat   out  DW     read data (zero on timeout)
rd_err   out  1      qualifies rd_vld; read ended by timeout

Behaviour:
- Reset (sync, rst=1 at posedge):
  - state=IDLE, cyc_o=0, stb_o=0, adr_o=0, rd_vld=0, rd_ch=0, rd_dat=0, rd_err=0, timeout counter=0.
  - arb_ack=1 (combinational, state==IDLE).
  - rst overrides any state, including mid-bus-cycle; cyc_o/stb_o drop the next edge and no rd_vld is produced.
- arb_ack = (state==IDLE). The arbiter updates sel/seln at an edge where ce & arb_ack.
- States: IDLE, GRANT, BUS, DONE.
- IDLE:
  - if ce=1 -> GRANT (arbiter samples at this same edge).
  - else stay.
- GRANT (sel/seln now settled):
  - if |sel and req[seln] -> BUS. Same edge: cyc_o=stb_o=1, adr_o=ch_adr[seln], rd_ch=seln, counter=0.
  - else -> IDLE with no bus cycle. This covers no owner yet, or a held stale owner whose request has dropped.
- BUS:
  - adr_o and rd_ch are held constant; req/sel changes are ignored.
  - Counter increments each clk, independent of ce.
  - if ack_i=1 -> DONE. Same edge: rd_dat=dat_i, rd_err=0, cyc_o=stb_o=0.
  - else if counter==TMO-1 -> DONE. Same edge: rd_dat=0, rd_err=1, cyc_o=stb_o=0.
  - ack_i takes priority over timeout on the same cycle.
- DONE:
  - rd_vld=1 for exactly this one cycle -> IDLE.
  - rd_dat/rd_ch/rd_err hold their values until the next DONE.
- rd_vld is registered: high only during the DONE cycle.
- ack_i while cyc_o=0 is ignored.
- Minimum transaction spacing is 4 clks: IDLE, GRANT, BUS (1 cycle with ack), DONE.
- Requester owns de-asserting req after its rd_vld. If req stays high, the channel is re-served on the next grant.
- Fixed-priority fairness is not altered by this block; it serves whatever the arbiter grants.

Test Plan:
- Reset mid-BUS: start a read on ch3, assert rst for 1 clk -> next clk cyc_o=0, stb_o=0, arb_ack=1, rd_vld never pulses.
- Single read: ce=1 continuous, req=8'h04, ch_adr[2]=24'h001234, ack_i returned 2 clks after stb_o with dat_i=16'hBEEF -> adr_o=24'h001234 during BUS; rd_vld pulse with rd_ch=2, rd_dat=16'hBEEF, rd_err=0; arb_ack low from GRANT through DONE.
- Priority and back-to-back: req=8'h81, each bus cycle acked immediately, ch0 drops req after its rd_vld -> first rd_ch=0, second rd_ch=7; 4 clks between rd_vld pulses.
- Timeout: TMO=8, ack_i held 0 -> cyc_o high for exactly 8 clks; rd_vld with rd_err=1, rd_dat=0; then arb_ack=1.
- Stale owner: grant ch5, complete the read, drop req5, all other req=0 -> next GRANT returns to IDLE with no cyc_o assertion and no rd_vld.
- ce gating: ce high 1 clk in 4, ch1 requesting -> IDLE->GRANT only on ce cycles; BUS duration and timeout counting unaffected by ce=0.
